// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
//   Fetches 32-bit instruction words from instruction memory and hands them to
//   decode through a 2-entry {word, pc} buffer. A 2-entry in-flight PC queue
//   tags each in-order memory response with its fetch address. Redirects from
//   decode withdraw the pending request, clear the buffer and drop responses
//   that are still in flight (FLUSH state).
//
//   Optional feature macro: FETCH_MISALIGN_TRAP_EN
//     defined   : a redirect with redirect_pc[1:0] != 0 halts fetching (HALT
//                 state) and raises a sticky fetch_fault until reset.
//     undefined : redirect_pc[1:0] is forced to 2'b00 and fetch_fault is 0.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc,
    output logic        fetch_fault
);

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

`ifdef FETCH_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HALT  = 2'd2
    } state_e;
`else
    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_FLUSH = 2'd1
    } state_e;
`endif

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        started_q;

    // instruction buffer (circular, 2 entries)
    logic [31:0] buf_word_q [2];
    logic [31:0] buf_pc_q   [2];
    logic        buf_rd_q, buf_rd_d;
    logic [1:0]  buf_cnt_q, buf_cnt_d;

    // in-flight PC queue (circular, 2 entries)
    logic [31:0] ifq_pc_q [2];
    logic        ifq_rd_q, ifq_rd_d;
    logic [1:0]  out_cnt_q, out_cnt_d;

    logic [1:0]  discard_cnt_q, discard_cnt_d;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic        fault_q, fault_d;
    logic        misalign_s;
`endif

    logic        req_valid_s;
    logic        fire_s;
    logic        resp_take_s;
    logic        push_s;
    logic        pop_s;
    logic [2:0]  occupancy_s;
    logic [31:0] redirect_tgt_s;
    logic        buf_wr_s;
    logic        ifq_wr_s;

    // A pop frees a slot this same cycle, which is what allows one request
    // per cycle in steady state with single-cycle memory.
    assign pop_s          = (buf_cnt_q != 2'd0) && instr_ready;
    assign occupancy_s    = {1'b0, buf_cnt_q} + {1'b0, out_cnt_q} - {2'b00, pop_s};
    assign redirect_tgt_s = redirect_pc & 32'hFFFF_FFFC;
    // Tail slot; when full the tail equals the head being popped this cycle.
    assign buf_wr_s       = buf_rd_q ^ buf_cnt_q[0];
    assign ifq_wr_s       = ifq_rd_q ^ out_cnt_q[0];
`ifdef FETCH_MISALIGN_TRAP_EN
    assign misalign_s     = (redirect_pc[1:0] != 2'b00);
`endif

    // Next-state logic for the fetch FSM, queues and counters.
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        buf_rd_d      = buf_rd_q;
        buf_cnt_d     = buf_cnt_q;
        ifq_rd_d      = ifq_rd_q;
        out_cnt_d     = out_cnt_q;
        discard_cnt_d = discard_cnt_q;
        req_valid_s   = 1'b0;
        fire_s        = 1'b0;
        resp_take_s   = 1'b0;
        push_s        = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        fault_d       = fault_q;
`endif
        case (state_q)
            ST_FETCH: begin
                if (redirect_valid) begin
                    // Request withdrawn, buffer and in-flight queue emptied;
                    // the in-flight responses become discards.
                    fetch_pc_d = redirect_tgt_s;
                    buf_cnt_d  = 2'd0;
                    buf_rd_d   = 1'b0;
                    out_cnt_d  = 2'd0;
                    ifq_rd_d   = 1'b0;
                    if (imem_resp_valid && (out_cnt_q != 2'd0)) begin
                        discard_cnt_d = out_cnt_q - 2'd1;
                    end else begin
                        discard_cnt_d = out_cnt_q;
                    end
`ifdef FETCH_MISALIGN_TRAP_EN
                    if (misalign_s) begin
                        state_d       = ST_HALT;
                        fault_d       = 1'b1;
                        discard_cnt_d = 2'd0;
                    end else begin
                        state_d = (discard_cnt_d != 2'd0) ? ST_FLUSH : ST_FETCH;
                    end
`else
                    state_d = (discard_cnt_d != 2'd0) ? ST_FLUSH : ST_FETCH;
`endif
                end else begin
                    req_valid_s = started_q && (occupancy_s < 3'd2);
                    fire_s      = req_valid_s && imem_req_ready;
                    resp_take_s = imem_resp_valid && (out_cnt_q != 2'd0);
                    push_s      = resp_take_s;
                    fetch_pc_d  = fire_s ? (fetch_pc_q + 32'd4) : fetch_pc_q;
                    out_cnt_d   = out_cnt_q + {1'b0, fire_s} - {1'b0, resp_take_s};
                    ifq_rd_d    = resp_take_s ? ~ifq_rd_q : ifq_rd_q;
                    buf_cnt_d   = buf_cnt_q + {1'b0, push_s} - {1'b0, pop_s};
                    buf_rd_d    = pop_s ? ~buf_rd_q : buf_rd_q;
                end
            end
            ST_FLUSH: begin
                buf_cnt_d = 2'd0;
                buf_rd_d  = 1'b0;
                out_cnt_d = 2'd0;
                ifq_rd_d  = 1'b0;
                if (imem_resp_valid && (discard_cnt_q != 2'd0)) begin
                    discard_cnt_d = discard_cnt_q - 2'd1;
                end else begin
                    discard_cnt_d = discard_cnt_q;
                end
                fetch_pc_d = redirect_valid ? redirect_tgt_s : fetch_pc_q;
`ifdef FETCH_MISALIGN_TRAP_EN
                if (redirect_valid && misalign_s) begin
                    state_d       = ST_HALT;
                    fault_d       = 1'b1;
                    discard_cnt_d = 2'd0;
                end else begin
                    state_d = (discard_cnt_d == 2'd0) ? ST_FETCH : ST_FLUSH;
                end
`else
                state_d = (discard_cnt_d == 2'd0) ? ST_FETCH : ST_FLUSH;
`endif
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            ST_HALT: begin
                state_d       = ST_HALT;
                buf_cnt_d     = 2'd0;
                buf_rd_d      = 1'b0;
                out_cnt_d     = 2'd0;
                ifq_rd_d      = 1'b0;
                discard_cnt_d = 2'd0;
                fault_d       = 1'b1;
            end
`endif
            default: begin
                state_d       = ST_FETCH;
                buf_cnt_d     = 2'd0;
                buf_rd_d      = 1'b0;
                out_cnt_d     = 2'd0;
                ifq_rd_d      = 1'b0;
                discard_cnt_d = 2'd0;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_FETCH;
            fetch_pc_q    <= RESET_PC;
            started_q     <= 1'b0;
            buf_rd_q      <= 1'b0;
            buf_cnt_q     <= 2'd0;
            ifq_rd_q      <= 1'b0;
            out_cnt_q     <= 2'd0;
            discard_cnt_q <= 2'd0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            started_q     <= 1'b1;
            buf_rd_q      <= buf_rd_d;
            buf_cnt_q     <= buf_cnt_d;
            ifq_rd_q      <= ifq_rd_d;
            out_cnt_q     <= out_cnt_d;
            discard_cnt_q <= discard_cnt_d;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    // Sticky misaligned-redirect fault, cleared only by reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end
`endif

    // Storage for buffered words and in-flight fetch addresses.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            buf_word_q[0] <= 32'd0;
            buf_word_q[1] <= 32'd0;
            buf_pc_q[0]   <= 32'd0;
            buf_pc_q[1]   <= 32'd0;
            ifq_pc_q[0]   <= 32'd0;
            ifq_pc_q[1]   <= 32'd0;
        end else begin
            if (push_s) begin
                buf_word_q[buf_wr_s] <= imem_resp_data;
                buf_pc_q[buf_wr_s]   <= ifq_pc_q[ifq_rd_q];
            end
            if (fire_s) begin
                ifq_pc_q[ifq_wr_s] <= fetch_pc_q;
            end
        end
    end

    assign imem_req_valid = req_valid_s;
    assign imem_req_addr  = fetch_pc_q;
    assign instr_valid    = (buf_cnt_q != 2'd0);
    assign instruction    = instr_valid ? buf_word_q[buf_rd_q] : NOP_WORD;
    assign instr_pc       = instr_valid ? buf_pc_q[buf_rd_q] : 32'd0;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign fetch_fault    = fault_q;
`else
    assign fetch_fault    = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit
//   Random traffic against a memory model with random ready/latency. The
//   reference keeps only the architectural view: the next PC decode must see,
//   the next address memory must be asked for, and how many stale responses
//   are still to be thrown away after a redirect.
module tb_instruction_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0100;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = 32'd0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic        fetch_fault;

    instruction_fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instruction    (instruction),
        .instr_pc       (instr_pc),
        .fetch_fault    (fetch_fault)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    // memory model: accepted requests awaiting their in-order response
    logic [31:0] mq_addr[$];
    int          mq_due[$];
    int          cyc = 0;

    // reference model
    logic [31:0] exp_pc;
    logic [31:0] exp_req;
    int          discard_exp;
    bit          halted;
    bit          prev_redir;
    bit          prev_pend;
    int          n_hs;
    bit          saw_wrap;

    // observations of the most recent cycle
    bit          g_redir;
    bit          g_req_valid;
    bit          g_instr_valid;
    int          g_qsize;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_1234;
    endfunction

    task automatic do_reset();
        @(posedge clock);
        #2;
        reset_n         = 1'b0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        redirect_valid  = 1'b0;
        instr_ready     = 1'b0;
        mq_addr.delete();
        mq_due.delete();
        #1;
        check_eq("rst_req_valid", imem_req_valid, 32'd0);
        check_eq("rst_instr_valid", instr_valid, 32'd0);
        check_eq("rst_instr_pc", instr_pc, 32'd0);
        check_eq("rst_instruction", instruction, NOP);
        check_eq("rst_fault", fetch_fault, 32'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        #1;
        check_eq("rel_req_valid", imem_req_valid, 32'd0);
        exp_pc      = RESET_PC;
        exp_req     = RESET_PC;
        discard_exp = 0;
        halted      = 1'b0;
        prev_redir  = 1'b0;
        prev_pend   = 1'b0;
    endtask

    // mode: 0 random redirect, 1 redirect with two responses outstanding and
    // none arriving, 2 redirect together with a response and a handshake,
    // 3 redirect now.
    task automatic step(input int p_mready, input int p_iready, input int p_redir,
                        input int max_lat, input int mode, input logic [31:0] tgt_fixed);
        bit          resp;
        bit          redir;
        bit          hs;
        bit          fire;
        int          qsz;
        logic [31:0] tgt;
        @(negedge clock);
        cyc++;
        resp            = (mq_addr.size() > 0) && (mq_due[0] <= cyc);
        imem_resp_valid = resp;
        imem_resp_data  = resp ? mem_word(mq_addr[0]) : $urandom;
        imem_req_ready  = ($urandom_range(99) < p_mready);
        instr_ready     = ($urandom_range(99) < p_iready);
        tgt   = tgt_fixed;
        redir = 1'b0;
        case (mode)
            0: if ($urandom_range(99) < p_redir) begin
                redir = 1'b1;
                tgt   = $urandom & 32'h0000_3FFF;
`ifdef FETCH_MISALIGN_TRAP_EN
                tgt   = tgt & 32'hFFFF_FFFC;
`endif
            end
            1: redir = (mq_addr.size() == 2) && !resp;
            2: if (resp && instr_valid) begin
                redir       = 1'b1;
                instr_ready = 1'b1;
            end
            3: redir = 1'b1;
            default: redir = 1'b0;
        endcase
        redirect_valid = redir;
        redirect_pc    = tgt;
        #1;
        g_redir       = redir;
        g_req_valid   = imem_req_valid;
        g_instr_valid = instr_valid;

        check_eq("fault", fetch_fault, halted);
        if (halted) begin
            check_eq("halt_no_req", imem_req_valid, 32'd0);
            check_eq("halt_empty", instr_valid, 32'd0);
        end
        if (prev_redir) check_eq("buf_cleared", instr_valid, 32'd0);
        if (redir) check_eq("req_withdrawn", imem_req_valid, 32'd0);
        if (discard_exp > 0) check_eq("flush_no_req", imem_req_valid, 32'd0);
        if (prev_pend && !redir) check_eq("req_held", imem_req_valid, 32'd1);
        if (!instr_valid) begin
            check_eq("idle_nop", instruction, NOP);
            check_eq("idle_pc", instr_pc, 32'd0);
        end

        hs = instr_valid && instr_ready;
        if (hs) begin
            check_eq("instr_pc", instr_pc, exp_pc);
            check_eq("instr_word", instruction, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
            n_hs++;
        end

        fire = imem_req_valid && imem_req_ready;
        if (fire) begin
            check_eq("req_addr", imem_req_addr, exp_req);
            if (imem_req_addr == 32'd0) saw_wrap = 1'b1;
            exp_req = exp_req + 32'd4;
        end

        qsz = mq_addr.size();
        if (resp) begin
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end
        if (fire) begin
            mq_addr.push_back(imem_req_addr);
            mq_due.push_back(cyc + int'($urandom_range(max_lat, 1)));
            check_eq("outstanding_le2", (mq_addr.size() <= 2), 32'd1);
        end
        g_qsize = mq_addr.size();

        prev_redir = redir && !halted;
        prev_pend  = imem_req_valid && !imem_req_ready && !redir;
        if (redir && !halted) begin
            discard_exp = qsz - (resp ? 1 : 0);
`ifdef FETCH_MISALIGN_TRAP_EN
            if (tgt[1:0] != 2'b00) halted = 1'b1;
`endif
            exp_pc  = tgt & 32'hFFFF_FFFC;
            exp_req = tgt & 32'hFFFF_FFFC;
        end else if (resp && (discard_exp > 0)) begin
            discard_exp--;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // streaming, all ready, single-cycle memory: 0x100, 0x104, 0x108 ...
        n_hs = 0;
        repeat (30) step(100, 100, 0, 1, 0, 32'd0);
        check_eq("throughput", (n_hs >= 25), 32'd1);

        // decode stalls: buffer fills, requests stop, nothing outstanding
        repeat (8) step(100, 0, 0, 1, 0, 32'd0);
        check_eq("stall_no_req", g_req_valid, 32'd0);
        check_eq("stall_buf_full", g_instr_valid, 32'd1);
        check_eq("stall_outstanding", g_qsize, 32'd0);
        repeat (10) step(100, 100, 0, 1, 0, 32'd0);

        // redirect to 0x200 with two responses in flight
        g_redir = 1'b0;
        for (int k = 0; k < 60 && !g_redir; k++) step(100, 100, 0, 3, 1, 32'h0000_0200);
        check_eq("redir2_seen", g_redir, 32'd1);
        repeat (20) step(100, 100, 0, 3, 0, 32'd0);

        // redirect coincident with a response and a handshake
        g_redir = 1'b0;
        for (int k = 0; k < 60 && !g_redir; k++) step(100, 100, 0, 1, 2, 32'h0000_0400);
        check_eq("coinc_seen", g_redir, 32'd1);
        repeat (15) step(100, 100, 0, 1, 0, 32'd0);

        // random traffic, reset in the middle of it
        repeat (300) step(70, 70, 4, 4, 0, 32'd0);
        do_reset();
        repeat (150) step(70, 70, 4, 4, 0, 32'd0);

        // address wrap 0xFFFF_FFFC -> 0x0000_0000
        saw_wrap = 1'b0;
        step(100, 100, 0, 1, 3, 32'hFFFF_FFF8);
        repeat (10) step(100, 100, 0, 1, 0, 32'd0);
        check_eq("wrap_req0", saw_wrap, 32'd1);

        // misaligned redirect: trap with the option, else fetch from 0x200
        step(100, 100, 0, 1, 3, 32'h0000_0202);
        repeat (12) step(100, 100, 0, 2, 0, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, which is the first fetch address after reset.
REQ-002 SHALL have port clock  in  1  (the single clock; all state on rising edge).
REQ-003 SHALL have port reset_n  in  1  (asynchronous, active-low reset).
REQ-004 SHALL have port imem_req_valid  out  1  (fetch request to instruction memory).
REQ-005 SHALL have port imem_req_ready  in  1  (memory accepts the request this cycle).
REQ-006 SHALL have port imem_req_addr  out  32  (word-aligned fetch address).
REQ-007 SHALL have port imem_resp_valid  in  1  (in-order response, one per accepted request, latency >=1 cycle).
REQ-008 SHALL have port imem_resp_data  in  32  (fetched instruction word).
REQ-009 SHALL have port redirect_valid  in  1  (taken jump/branch from decode, i.e. PC_IN_MUX_SEL).
REQ-010 SHALL have port redirect_pc  in  32  (redirect target).
REQ-011 SHALL have port instr_valid  out  1  (instruction available to decode).
REQ-012 SHALL have port instr_ready  in  1  (decode consumes this cycle).
REQ-013 SHALL have port instruction  out  32  (buffer-head word; 32'h0000_0013 NOP when instr_valid=0).
REQ-014 SHALL have port instr_pc  out  32  (PC of the buffer-head word; 0 when empty).
REQ-015 SHALL have port fetch_fault  out  1  (sticky misaligned-redirect fault).

Function
REQ-016 SHALL hold fetch_pc; each accepted request (valid&ready) SHALL advance it by 4, wrapping 32'hFFFF_FFFC->0.
REQ-017 SHALL keep a 2-entry instruction buffer {word, pc} plus a 2-entry in-flight PC queue; a request SHALL be issued only when occupancy+outstanding < 2.
REQ-018 SHALL drive imem_req_addr = fetch_pc while imem_req_valid is high; the request SHALL be held stable until accepted, unless a redirect occurs.
REQ-019 SHALL write a response into the buffer tagged with the popped in-flight PC; instr_valid SHALL rise the cycle after the response (no bypass).
REQ-020 SHALL pop the buffer head on instr_valid&instr_ready; a simultaneous push and pop SHALL be legal when full.
REQ-021 SHALL implement FSM states FETCH, FLUSH and HALT (HALT exists only with the macro).
REQ-022 On redirect_valid in FETCH: imem_req_valid=0 that cycle (pending request withdrawn), fetch_pc<=redirect_pc, buffer cleared next cycle, discard_cnt<=outstanding (less 1 if a response arrives the same cycle, which is dropped); go to FLUSH if discard_cnt>0, else stay in FETCH.
REQ-023 In FLUSH: no requests; each response SHALL be dropped and decrement discard_cnt; at 0 go to FETCH.
REQ-024 A redirect in FLUSH SHALL replace fetch_pc and keep the discard count.
REQ-025 A handshake in the redirect cycle SHALL complete; the remaining entries are then flushed.
REQ-026 Best-case throughput SHALL be one instruction per cycle with single-cycle memory.

Reset
REQ-027 On reset_n=0 (asynchronous): state=FETCH, fetch_pc=RESET_PC, buffer and queues empty, discard_cnt=0, imem_req_valid=0, instr_valid=0, instr_pc=0, instruction=NOP, fetch_fault=0.
REQ-028 SHALL issue the first request no earlier than the first clock edge after reset_n deasserts; reset mid-transaction SHALL abandon all outstanding responses.

Configuration
REQ-029 With FETCH_MISALIGN_TRAP_EN defined: a redirect with redirect_pc[1:0]!=0 SHALL enter HALT, set fetch_fault=1 until reset, flush the buffer, issue no requests and drop all responses.
REQ-030 Without FETCH_MISALIGN_TRAP_EN: redirect_pc[1:0] SHALL be forced to 2'b00, HALT SHALL not exist, and fetch_fault SHALL be tied to 0.

Verification
REQ-031 SHALL cover: reset release, RESET_PC=0x100, memory ready/1-cycle latency, instr_ready=1 -> requests to 0x100,0x104,0x108; instr_pc follows with one instruction per cycle.
REQ-032 SHALL cover: instr_ready=0 for 5 cycles -> at most 2 buffered + 0 outstanding, requests stop, no word lost or duplicated on resume.
REQ-033 SHALL cover: redirect to 0x200 with 2 outstanding -> both responses dropped, FLUSH held 2 responses, next instr_pc=0x200.
REQ-034 SHALL cover: redirect coincident with a response and with a handshake -> response dropped, handshake counted once, buffer empty next cycle.
REQ-035 SHALL cover: fetch_pc=0xFFFF_FFFC -> next request address 0x0000_0000.
REQ-036 SHALL cover: redirect to 0x202 -> with the macro, fetch_fault=1 and imem_req_valid=0 permanently; without it, fetch from 0x200.
